// File: rtl/axis_bram_adapter_pkg.sv
// Shared constants for the AXI-Stream <-> wide-BRAM adapter: register map,
// control/status bit positions and the transfer FSM state encoding.
package axis_bram_adapter_pkg;

   localparam int REG_CTRL   = 'h00;
   localparam int REG_START  = 'h04;
   localparam int REG_END    = 'h08;
   localparam int REG_STATUS = 'h0C;

   localparam int CTRL_RW_BIT     = 0;
   localparam int CTRL_RELOAD_BIT = 1;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_COLLECT,
      ST_WR_COMMIT,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_RD_STREAM,
      ST_DONE
   } state_t;

endpackage

// File: rtl/axis_bram_adapter_regs.sv
// AXI4-Lite register slave: CTRL/START/END storage, STATUS readback and a
// one-cycle reload_pulse whenever CTRL is written with the RELOAD bit set.
module axis_bram_adapter_regs #(
   parameter int DATA_W  = 32,
   parameter int BRAM_AW = 12,
   parameter int LITE_AW = 5
) (
   input  logic               clk,
   input  logic               srst,
   input  logic [LITE_AW-1:0] awaddr,
   input  logic [2:0]         awprot,
   input  logic               awvalid,
   output logic               awready,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic               wvalid,
   output logic               wready,
   output logic [1:0]         bresp,
   output logic               bvalid,
   input  logic               bready,
   input  logic [LITE_AW-1:0] araddr,
   input  logic [2:0]         arprot,
   input  logic               arvalid,
   output logic               arready,
   output logic [DATA_W-1:0]  rdata,
   output logic [1:0]         rresp,
   output logic               rvalid,
   input  logic               rready,
   input  logic               busy,
   input  logic               done,
   output logic               ctrl_rw,
   output logic [BRAM_AW-1:0] start_addr,
   output logic [BRAM_AW-1:0] end_addr,
   output logic               reload_pulse
);
   import axis_bram_adapter_pkg::*;

   localparam int NBYTES = DATA_W / 8;

   logic               awready_reg, bvalid_reg, arready_reg, rvalid_reg;
   logic               rw_reg, reload_reg;
   logic [BRAM_AW-1:0] start_reg, end_reg;
   logic [DATA_W-1:0]  rdata_reg, rd_mux, wmask;
   logic               aw_hs, ar_hs;
   logic               unused_lite;

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_wmask
         assign wmask[gi*8 +: 8] = {8{wstrb[gi]}};
      end
   endgenerate

   assign aw_hs = awready_reg && awvalid && wvalid;
   assign ar_hs = arready_reg && arvalid;

   always_comb begin
      rd_mux = '0;
      case (araddr)
         LITE_AW'(REG_CTRL):   rd_mux[CTRL_RW_BIT] = rw_reg;
         LITE_AW'(REG_START):  rd_mux[BRAM_AW-1:0] = start_reg;
         LITE_AW'(REG_END):    rd_mux[BRAM_AW-1:0] = end_reg;
         LITE_AW'(REG_STATUS): begin
            rd_mux[STATUS_BUSY_BIT] = busy;
            rd_mux[STATUS_DONE_BIT] = done;
         end
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         awready_reg <= 1'b0;
         bvalid_reg  <= 1'b0;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rw_reg      <= 1'b0;
         reload_reg  <= 1'b0;
         start_reg   <= '0;
         end_reg     <= '0;
      end else begin
         // Single-cycle ready pulse; the !awready term stops a second pulse on the handshake edge.
         awready_reg <= awvalid && wvalid && !bvalid_reg && !awready_reg;
         reload_reg  <= 1'b0;
         if (aw_hs) begin
            bvalid_reg <= 1'b1;
            case (awaddr)
               LITE_AW'(REG_CTRL): if (wstrb[0]) begin
                  rw_reg     <= wdata[CTRL_RW_BIT];
                  reload_reg <= wdata[CTRL_RELOAD_BIT];
               end
               LITE_AW'(REG_START):
                  start_reg <= (start_reg & ~wmask[BRAM_AW-1:0]) | (wdata[BRAM_AW-1:0] & wmask[BRAM_AW-1:0]);
               LITE_AW'(REG_END):
                  end_reg <= (end_reg & ~wmask[BRAM_AW-1:0]) | (wdata[BRAM_AW-1:0] & wmask[BRAM_AW-1:0]);
               default: ;
            endcase
         end else if (bvalid_reg && bready) begin
            bvalid_reg <= 1'b0;
         end

         arready_reg <= arvalid && !rvalid_reg && !arready_reg;
         if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_mux;
         end else if (rvalid_reg && rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

   assign awready      = awready_reg;
   assign wready       = awready_reg;
   assign bvalid       = bvalid_reg;
   assign bresp        = 2'b00;
   assign arready      = arready_reg;
   assign rvalid       = rvalid_reg;
   assign rdata        = rdata_reg;
   assign rresp        = 2'b00;
   assign ctrl_rw      = rw_reg;
   assign start_addr   = start_reg;
   assign end_addr     = end_reg;
   assign reload_pulse = reload_reg;
   assign unused_lite  = ^{awprot, arprot, wmask[DATA_W-1:BRAM_AW], wdata[DATA_W-1:BRAM_AW]};

endmodule

// File: rtl/axis_bram_adapter.sv
// Stream <-> BRAM bridge: packs 36 stream beats into one BRAM line on write,
// and serialises each BRAM line into 36 stream beats on read.
module axis_bram_adapter #(
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 36,
   parameter int BRAM_AW        = 12,
   parameter int LITE_AW        = 5
) (
   input  logic                             aclk,
   input  logic                             areset,
   output logic                             BRAM_CLK,
   output logic                             BRAM_EN,
   output logic                             BRAM_WEN,
   output logic [BRAM_AW-1:0]               BRAM_ADDR,
   output logic [DATA_W*WORDS_PER_LINE-1:0] BRAM_IN,
   input  logic [DATA_W*WORDS_PER_LINE-1:0] BRAM_OUT,
   input  logic [DATA_W-1:0]                s00_axis_tdata,
   input  logic [DATA_W/8-1:0]              s00_axis_tstrb,
   input  logic                             s00_axis_tlast,
   input  logic                             s00_axis_tvalid,
   output logic                             s00_axis_tready,
   output logic [DATA_W-1:0]                m00_axis_tdata,
   output logic [DATA_W/8-1:0]              m00_axis_tstrb,
   output logic                             m00_axis_tlast,
   output logic                             m00_axis_tvalid,
   input  logic                             m00_axis_tready,
   input  logic [LITE_AW-1:0]               s02_axi_awaddr,
   input  logic [2:0]                       s02_axi_awprot,
   input  logic                             s02_axi_awvalid,
   output logic                             s02_axi_awready,
   input  logic [DATA_W-1:0]                s02_axi_wdata,
   input  logic [DATA_W/8-1:0]              s02_axi_wstrb,
   input  logic                             s02_axi_wvalid,
   output logic                             s02_axi_wready,
   output logic [1:0]                       s02_axi_bresp,
   output logic                             s02_axi_bvalid,
   input  logic                             s02_axi_bready,
   input  logic [LITE_AW-1:0]               s02_axi_araddr,
   input  logic [2:0]                       s02_axi_arprot,
   input  logic                             s02_axi_arvalid,
   output logic                             s02_axi_arready,
   output logic [DATA_W-1:0]                s02_axi_rdata,
   output logic [1:0]                       s02_axi_rresp,
   output logic                             s02_axi_rvalid,
   input  logic                             s02_axi_rready
);
   import axis_bram_adapter_pkg::*;

   localparam int SLOT_W = $clog2(WORDS_PER_LINE);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORDS_PER_LINE - 1);

   state_t             state_reg;
   logic [BRAM_AW-1:0] ptr_reg;
   logic [SLOT_W-1:0]  slot_reg;
   logic [DATA_W-1:0]  line_reg [WORDS_PER_LINE];
   logic               last_seen_reg, done_reg;
   logic               bram_en_reg, bram_wen_reg, s_tready_reg, m_tvalid_reg, m_tlast_reg;
   logic               ctrl_rw, reload_pulse, busy;
   logic [BRAM_AW-1:0] start_addr, end_addr;
   logic               unused_strb;

   axis_bram_adapter_regs #(.DATA_W(DATA_W), .BRAM_AW(BRAM_AW), .LITE_AW(LITE_AW)) u_regs (
      .clk(aclk), .srst(areset),
      .awaddr(s02_axi_awaddr), .awprot(s02_axi_awprot), .awvalid(s02_axi_awvalid), .awready(s02_axi_awready),
      .wdata(s02_axi_wdata), .wstrb(s02_axi_wstrb), .wvalid(s02_axi_wvalid), .wready(s02_axi_wready),
      .bresp(s02_axi_bresp), .bvalid(s02_axi_bvalid), .bready(s02_axi_bready),
      .araddr(s02_axi_araddr), .arprot(s02_axi_arprot), .arvalid(s02_axi_arvalid), .arready(s02_axi_arready),
      .rdata(s02_axi_rdata), .rresp(s02_axi_rresp), .rvalid(s02_axi_rvalid), .rready(s02_axi_rready),
      .busy(busy), .done(done_reg),
      .ctrl_rw(ctrl_rw), .start_addr(start_addr), .end_addr(end_addr), .reload_pulse(reload_pulse)
   );

   generate
      for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_line_out
         assign BRAM_IN[gi*DATA_W +: DATA_W] = line_reg[gi];
      end
   endgenerate

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         slot_reg      <= '0;
         last_seen_reg <= 1'b0;
         done_reg      <= 1'b0;
         bram_en_reg   <= 1'b0;
         bram_wen_reg  <= 1'b0;
         s_tready_reg  <= 1'b0;
         m_tvalid_reg  <= 1'b0;
         m_tlast_reg   <= 1'b0;
         for (int i = 0; i < WORDS_PER_LINE; i++) line_reg[i] <= '0;
      end else if (reload_pulse) begin
         // RELOAD restarts from any state, including mid-transfer.
         ptr_reg       <= start_addr;
         slot_reg      <= '0;
         last_seen_reg <= 1'b0;
         done_reg      <= 1'b0;
         m_tvalid_reg  <= 1'b0;
         m_tlast_reg   <= 1'b0;
         bram_wen_reg  <= 1'b0;
         for (int i = 0; i < WORDS_PER_LINE; i++) line_reg[i] <= '0;
         if (ctrl_rw) begin
            state_reg    <= ST_WR_COLLECT;
            s_tready_reg <= 1'b1;
            bram_en_reg  <= 1'b0;
         end else begin
            state_reg    <= ST_RD_ISSUE;
            s_tready_reg <= 1'b0;
            bram_en_reg  <= 1'b1;
         end
      end else begin
         case (state_reg)
            ST_WR_COLLECT: if (s00_axis_tvalid && s_tready_reg) begin
               line_reg[slot_reg] <= s00_axis_tdata;
               if (slot_reg == LAST_SLOT || s00_axis_tlast) begin
                  state_reg     <= ST_WR_COMMIT;
                  s_tready_reg  <= 1'b0;
                  bram_en_reg   <= 1'b1;
                  bram_wen_reg  <= 1'b1;
                  last_seen_reg <= s00_axis_tlast;
               end else begin
                  slot_reg <= slot_reg + 1'b1;
               end
            end
            ST_WR_COMMIT: begin
               bram_en_reg  <= 1'b0;
               bram_wen_reg <= 1'b0;
               slot_reg     <= '0;
               for (int i = 0; i < WORDS_PER_LINE; i++) line_reg[i] <= '0;
               if (last_seen_reg || ptr_reg == end_addr) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end else begin
                  ptr_reg      <= ptr_reg + 1'b1;
                  state_reg    <= ST_WR_COLLECT;
                  s_tready_reg <= 1'b1;
               end
            end
            ST_RD_ISSUE: begin
               bram_en_reg <= 1'b0;
               state_reg   <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               for (int i = 0; i < WORDS_PER_LINE; i++) line_reg[i] <= BRAM_OUT[i*DATA_W +: DATA_W];
               state_reg    <= ST_RD_STREAM;
               m_tvalid_reg <= 1'b1;
               m_tlast_reg  <= (LAST_SLOT == '0) && (ptr_reg == end_addr);
            end
            ST_RD_STREAM: if (m00_axis_tready) begin
               if (slot_reg == LAST_SLOT) begin
                  m_tvalid_reg <= 1'b0;
                  m_tlast_reg  <= 1'b0;
                  slot_reg     <= '0;
                  if (ptr_reg == end_addr) begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     ptr_reg     <= ptr_reg + 1'b1;
                     state_reg   <= ST_RD_ISSUE;
                     bram_en_reg <= 1'b1;
                  end
               end else begin
                  slot_reg    <= slot_reg + 1'b1;
                  m_tlast_reg <= (slot_reg + 1'b1 == LAST_SLOT) && (ptr_reg == end_addr);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy            = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign BRAM_CLK        = aclk;
   assign BRAM_EN         = bram_en_reg;
   assign BRAM_WEN        = bram_wen_reg;
   assign BRAM_ADDR       = ptr_reg;
   assign s00_axis_tready = s_tready_reg;
   assign m00_axis_tvalid = m_tvalid_reg;
   assign m00_axis_tlast  = m_tlast_reg;
   assign m00_axis_tdata  = line_reg[slot_reg];
   assign m00_axis_tstrb  = m_tvalid_reg ? {(DATA_W/8){1'b1}} : '0;
   assign unused_strb     = ^s00_axis_tstrb;

endmodule

// File: tb/tb_axis_bram_adapter.sv
// Directed bench for axis_bram_adapter with a 1-cycle-latency BRAM model.
module tb_axis_bram_adapter;
   localparam int LW = 1152;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          BRAM_CLK, BRAM_EN, BRAM_WEN;
   logic [11:0]   BRAM_ADDR;
   logic [LW-1:0] BRAM_IN, BRAM_OUT;
   logic [31:0]   s_tdata = '0, m_tdata;
   logic [3:0]    s_tstrb = '0, m_tstrb;
   logic          s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
   logic          m_tlast, m_tvalid, m_tready = 1'b0;
   logic [4:0]    awaddr = '0, araddr = '0;
   logic [2:0]    awprot = '0, arprot = '0;
   logic          awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
   logic [31:0]   wdata = '0, rdata;
   logic [3:0]    wstrb = '0;
   logic [1:0]    bresp, rresp;
   logic          arvalid = 1'b0, arready, rvalid, rready = 1'b0;

   always #5 aclk = ~aclk;

   axis_bram_adapter dut (
      .aclk(aclk), .areset(areset), .BRAM_CLK(BRAM_CLK), .BRAM_EN(BRAM_EN), .BRAM_WEN(BRAM_WEN),
      .BRAM_ADDR(BRAM_ADDR), .BRAM_IN(BRAM_IN), .BRAM_OUT(BRAM_OUT),
      .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
      .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
      .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast),
      .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
      .s02_axi_awaddr(awaddr), .s02_axi_awprot(awprot), .s02_axi_awvalid(awvalid), .s02_axi_awready(awready),
      .s02_axi_wdata(wdata), .s02_axi_wstrb(wstrb), .s02_axi_wvalid(wvalid), .s02_axi_wready(wready),
      .s02_axi_bresp(bresp), .s02_axi_bvalid(bvalid), .s02_axi_bready(bready),
      .s02_axi_araddr(araddr), .s02_axi_arprot(arprot), .s02_axi_arvalid(arvalid), .s02_axi_arready(arready),
      .s02_axi_rdata(rdata), .s02_axi_rresp(rresp), .s02_axi_rvalid(rvalid), .s02_axi_rready(rready)
   );

   // Single-port BRAM model, 1-cycle read latency.
   logic [LW-1:0] mem [4096];
   int wr_count = 0;
   int cyc = 0;
   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (BRAM_EN) begin
         if (BRAM_WEN) begin
            mem[BRAM_ADDR] <= BRAM_IN;
            wr_count <= wr_count + 1;
         end else begin
            BRAM_OUT <= mem[BRAM_ADDR];
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end else begin
         $display("ok   %s", name);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timeout, handshake never seen", name);
   endtask

   task automatic lite_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output int hs);
      int n;
      @(negedge aclk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while (!awready && n < 20) begin @(negedge aclk); n++; end
      if (!awready) timeout("lite_aw");
      @(posedge aclk); #1;
      hs = cyc;
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge aclk); n++; end
      if (!bvalid) timeout("lite_b");
      @(posedge aclk); #1;
      bready = 1'b0;
   endtask

   task automatic lite_read(input logic [4:0] a, output logic [31:0] d);
      int n;
      @(negedge aclk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(negedge aclk); n++; end
      if (!arready) timeout("lite_ar");
      @(posedge aclk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin @(negedge aclk); n++; end
      if (!rvalid) timeout("lite_r");
      d = rdata;
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l);
      int n;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      n = 0;
      while (!s_tready && n < 100) begin @(negedge aclk); n++; end
      if (!s_tready) timeout("s_axis");
      @(posedge aclk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   logic [31:0] got_d [$];
   logic        got_l [$];
   int          hold_errs, strb_errs;

   task automatic recv(input int nbeats, input bit toggle);
      int n;
      bit stalled;
      logic [31:0] held;
      got_d.delete(); got_l.delete();
      n = 0; stalled = 0; held = '0;
      while (got_d.size() < nbeats && n < 2000) begin
         @(negedge aclk);
         n++;
         m_tready = toggle ? n[0] : 1'b1;
         if (stalled && (!m_tvalid || m_tdata !== held)) hold_errs++;
         stalled = 0;
         if (m_tvalid) begin
            if (m_tstrb !== 4'hF) strb_errs++;
            if (m_tready) begin
               got_d.push_back(m_tdata);
               got_l.push_back(m_tlast);
            end else begin
               stalled = 1;
               held = m_tdata;
            end
         end
      end
      if (got_d.size() < nbeats) timeout("m_axis");
      @(posedge aclk); #1;
      m_tready = 1'b0;
   endtask

   function automatic logic [LW-1:0] alt_line(input logic [31:0] even_w, input logic [31:0] odd_w);
      logic [LW-1:0] l;
      for (int i = 0; i < 36; i++) l[i*32 +: 32] = (i % 2 == 0) ? even_w : odd_w;
      return l;
   endfunction

   function automatic logic [31:0] rd_expect(input int k);
      int w;
      w = k % 36;
      if (k < 36) return (w % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      return (w % 2 == 0) ? 32'hAAAA_AAAA : 32'hCCCC_CCCC;
   endfunction

   typedef struct {
      string       name;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [4:0]  raddr;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs [8];

   task automatic check_stream(input string tag);
      int derr, lerr;
      derr = 0; lerr = 0;
      for (int k = 0; k < got_d.size(); k++) begin
         if (got_d[k] !== rd_expect(k)) derr++;
         if (got_l[k] !== (k == 71)) lerr++;
      end
      chk({tag, "_beats"}, 64'(got_d.size()), 64'd72);
      chk({tag, "_data_errs"}, 64'(derr), 64'd0);
      chk({tag, "_tlast_errs"}, 64'(lerr), 64'd0);
   endtask

   initial begin
      int hs, base, lat, n;
      logic [31:0] rd;
      logic [LW-1:0] exp_line;

      vecs[0] = '{"start_full",    5'h04, 32'h0000_0ABC, 4'hF, 5'h04, 32'h0000_0ABC};
      vecs[1] = '{"end_trunc",     5'h08, 32'h1234_5FFF, 4'hF, 5'h08, 32'h0000_0FFF};
      vecs[2] = '{"start_byte0",   5'h04, 32'h0000_0123, 4'h1, 5'h04, 32'h0000_0A23};
      vecs[3] = '{"start_byte1",   5'h04, 32'h0000_0F00, 4'h2, 5'h04, 32'h0000_0F23};
      vecs[4] = '{"unmapped",      5'h10, 32'hFFFF_FFFF, 4'hF, 5'h10, 32'h0000_0000};
      vecs[5] = '{"ctrl_rw_only",  5'h00, 32'h0000_0001, 4'hF, 5'h00, 32'h0000_0001};
      vecs[6] = '{"ctrl_no_strb",  5'h00, 32'h0000_0002, 4'h0, 5'h00, 32'h0000_0001};
      vecs[7] = '{"status_idle",   5'h14, 32'h0000_0000, 4'hF, 5'h0C, 32'h0000_0000};

      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(negedge aclk);
      chk("rst_bram_ctl", 64'({BRAM_EN, BRAM_WEN, BRAM_ADDR}), 64'd0);
      chk("rst_bram_in", 64'(|BRAM_IN), 64'd0);
      chk("rst_streams", 64'({s_tready, m_tvalid, m_tlast, m_tstrb, m_tdata}), 64'd0);
      chk("rst_lite", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata}), 64'd0);

      for (int i = 0; i < 8; i++) begin
         lite_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, hs);
         lite_read(vecs[i].raddr, rd);
         chk(vecs[i].name, 64'(rd), 64'(vecs[i].exp));
      end

      // Write mode, START=0 END=8, tlast cuts the third line short.
      lite_write(5'h04, 32'd0, 4'hF, hs);
      lite_write(5'h08, 32'd8, 4'hF, hs);
      base = wr_count;
      lite_write(5'h00, 32'h3, 4'hF, hs);
      for (int k = 0; k < 36; k++) send_beat((k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 1'b0);
      for (int k = 0; k < 36; k++) send_beat((k % 2 == 0) ? 32'hAAAA_AAAA : 32'hCCCC_CCCC, 1'b0);
      send_beat(32'hCCCC_CCCC, 1'b1);
      lite_read(5'h0C, rd);
      chk("wr_status_done", 64'(rd), 64'h2);
      chk("wr_line_count", 64'(wr_count - base), 64'd3);
      chk_line("wr_line0", mem[0], alt_line(32'hFFFF_FFFF, 32'h0));
      chk_line("wr_line1", mem[1], alt_line(32'hAAAA_AAAA, 32'hCCCC_CCCC));
      exp_line = '0;
      exp_line[31:0] = 32'hCCCC_CCCC;
      chk_line("wr_line2", mem[2], exp_line);

      // Read mode, START=0 END=1, full-rate sink.
      hold_errs = 0; strb_errs = 0;
      lite_write(5'h08, 32'd1, 4'hF, hs);
      lite_write(5'h00, 32'h2, 4'hF, hs);
      n = 0;
      while (!m_tvalid && n < 20) begin @(negedge aclk); n++; end
      lat = cyc - hs;
      chk("rd_first_latency", 64'(lat), 64'd3);
      recv(72, 1'b0);
      check_stream("rd");
      chk("rd_strb_errs", 64'(strb_errs), 64'd0);
      m_tready = 1'b1;
      repeat (4) @(negedge aclk);
      chk("rd_no_extra_beat", 64'(m_tvalid), 64'd0);
      m_tready = 1'b0;
      lite_read(5'h0C, rd);
      chk("rd_status_done", 64'(rd), 64'h2);

      // Same read with a sink that stalls every other cycle.
      hold_errs = 0;
      lite_write(5'h00, 32'h2, 4'hF, hs);
      recv(72, 1'b1);
      check_stream("rd_toggle");
      chk("rd_toggle_hold_errs", 64'(hold_errs), 64'd0);

      // Wrap-around write: START=4095, END=0.
      lite_write(5'h04, 32'hFFF, 4'hF, hs);
      lite_write(5'h08, 32'h0, 4'hF, hs);
      base = wr_count;
      lite_write(5'h00, 32'h3, 4'hF, hs);
      for (int k = 0; k < 72; k++) send_beat(32'h5A00_0000 + k, 1'b0);
      lite_read(5'h0C, rd);
      chk("wrap_status_done", 64'(rd), 64'h2);
      chk("wrap_line_count", 64'(wr_count - base), 64'd2);
      for (int i = 0; i < 36; i++) exp_line[i*32 +: 32] = 32'h5A00_0000 + i;
      chk_line("wrap_line4095", mem[4095], exp_line);
      for (int i = 0; i < 36; i++) exp_line[i*32 +: 32] = 32'h5A00_0000 + 36 + i;
      chk_line("wrap_line0", mem[0], exp_line);

      // Reset in the middle of a line: nothing may reach the BRAM.
      lite_write(5'h04, 32'd10, 4'hF, hs);
      lite_write(5'h08, 32'd10, 4'hF, hs);
      lite_write(5'h00, 32'h3, 4'hF, hs);
      base = wr_count;
      for (int k = 0; k < 20; k++) send_beat(32'h7700_0000 + k, 1'b0);
      areset = 1'b1;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      s_tdata = 32'hDEAD_BEEF; s_tvalid = 1'b1;
      repeat (4) @(negedge aclk);
      chk("rst_mid_tready", 64'(s_tready), 64'd0);
      chk("rst_mid_bram_en", 64'(BRAM_EN), 64'd0);
      chk("rst_mid_no_write", 64'(wr_count - base), 64'd0);
      s_tvalid = 1'b0;
      lite_read(5'h0C, rd);
      chk("rst_mid_status_idle", 64'(rd), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule
